// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_pkg
//  Purpose  : Shared definitions for the UART command-frame unpacker:
//             default header byte, error codes and FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package uart_frame_pkg;

  localparam logic [7:0] HDR_BYTE_DFLT = 8'hA5;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    CHK   = 3'd3,
    DRAIN = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/uart_frame_buf.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_buf
//  Purpose  : Payload buffer, MAX_LEN x 8 register array. Synchronous write,
//             asynchronous read.
//  Ports    : clk      - clock
//             wr_en    - write strobe
//             wr_addr  - write index
//             wr_data  - write byte
//             rd_addr  - read index
//             rd_data  - byte at rd_addr (0 when rd_addr is out of range)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_frame_buf #(
  parameter int MAX_LEN = 64,
  parameter int PTR_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [7:0] mem_q [MAX_LEN];

  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_LEN; i++) begin
      if (wr_en && (wr_addr == PTR_W'(i))) begin
        mem_q[i] <= wr_data;
      end
    end
  end

  // Compare-based read mux: the pointer is one bit wider than a pure array
  // index, and the read pointer steps one past the end after the last beat.
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (rd_addr == PTR_W'(i)) begin
        rd_data = mem_q[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_axis_unpacker.sv
`default_nettype none
// ============================================================================
//  Module   : uart_axis_unpacker
//  Purpose  : Hunts HDR, LEN, payload[LEN], CHK frames in a UART RX byte
//             stream, buffers the payload and releases it on an AXI-Stream
//             master (tlast on the final byte) once the checksum matches.
//             Checksum = LEN + sum(payload), mod 256.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             s_axis_*          - RX byte stream in (tdata/tvalid/tready)
//             m_axis_*          - payload out (tdata/tvalid/tready/tlast)
//             frame_busy        - frame in progress (HDR accepted .. end)
//             frame_done        - 1-cycle pulse after tlast handshake
//             frame_err         - 1-cycle pulse on frame abort
//             err_code          - last error: 1 bad LEN, 2 checksum, 3 timeout
//  Options  : UART_UNPACK_TIMEOUT_EN - abort a frame stalled mid-frame for
//             TIMEOUT_CYCLES consecutive idle cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_axis_unpacker
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE       = HDR_BYTE_DFLT,
  parameter int         MAX_LEN        = 64,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int PTR_W = $clog2(MAX_LEN + 1);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] len_q, len_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       sum_q, sum_d;
  logic             tvalid_q, tvalid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic             in_hs;
  logic             out_hs;
  logic             buf_wr_en;
  logic             rd_last;

`ifdef UART_UNPACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] idle_q, idle_d;
`endif

  // RX is held off while draining so input and output never overlap.
  assign s_axis_tready = (state_q != DRAIN);
  assign in_hs         = s_axis_tvalid & s_axis_tready;
  assign out_hs        = tvalid_q & m_axis_tready;
  assign buf_wr_en     = in_hs && (state_q == DATA);
  assign rd_last       = (rd_ptr_q == (len_q - PTR_W'(1)));

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .PTR_W   (PTR_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (s_axis_tdata),
    .rd_addr (rd_ptr_q),
    .rd_data (m_axis_tdata)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sum_d      = sum_q;
    tvalid_d   = tvalid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    case (state_q)
      HUNT: begin
        if (in_hs && (s_axis_tdata == HDR_BYTE)) begin
          state_d = LEN;
          busy_d  = 1'b1;
        end
      end

      LEN: begin
        if (in_hs) begin
          if ((s_axis_tdata == 8'h00) || (s_axis_tdata > 8'(MAX_LEN))) begin
            state_d    = HUNT;
            busy_d     = 1'b0;
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
          end else begin
            state_d  = DATA;
            len_d    = PTR_W'(s_axis_tdata);
            sum_d    = s_axis_tdata;
            wr_ptr_d = '0;
          end
        end
      end

      DATA: begin
        // A header byte here is ordinary payload; no resync.
        if (in_hs) begin
          sum_d    = sum_q + s_axis_tdata;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (wr_ptr_q == (len_q - PTR_W'(1))) begin
            state_d = CHK;
          end
        end
      end

      CHK: begin
        if (in_hs) begin
          if (s_axis_tdata == sum_q) begin
            state_d  = DRAIN;
            rd_ptr_d = '0;
            tvalid_d = 1'b1;
          end else begin
            state_d    = HUNT;
            busy_d     = 1'b0;
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
          end
        end
      end

      DRAIN: begin
        if (out_hs) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          if (rd_last) begin
            state_d  = HUNT;
            tvalid_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d  = HUNT;
        tvalid_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase

`ifdef UART_UNPACK_TIMEOUT_EN
    // Counts idle cycles only while staying in LEN/DATA/CHK; any accepted
    // byte or state change restarts it from zero.
    idle_d = '0;
    if (((state_q == LEN) || (state_q == DATA) || (state_q == CHK)) && !in_hs) begin
      if (idle_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d    = HUNT;
        busy_d     = 1'b0;
        err_d      = 1'b1;
        err_code_d = ERR_TMO;
      end else begin
        idle_d = idle_q + TMO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      len_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sum_q      <= 8'h00;
      tvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
`ifdef UART_UNPACK_TIMEOUT_EN
      idle_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sum_q      <= sum_d;
      tvalid_q   <= tvalid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
`ifdef UART_UNPACK_TIMEOUT_EN
      idle_q     <= idle_d;
`endif
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tvalid_q & rd_last;
  assign frame_busy    = busy_q;
  assign frame_done    = done_q;
  assign frame_err     = err_q;
  assign err_code      = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_axis_unpacker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_axis_unpacker
//  Purpose  : Self-checking bench for uart_axis_unpacker. Frame vectors from a
//             table, expected beats kept in a scoreboard queue and checked by
//             a monitor, plus hand-written backpressure / max-length /
//             timeout / reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_axis_unpacker;

  localparam int MAX_LEN = 64;
  localparam int TMO     = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] code;

  always #5 clk = ~clk;

  uart_axis_unpacker #(
    .HDR_BYTE       (8'hA5),
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .frame_busy    (busy),
    .frame_done    (done),
    .frame_err     (err),
    .err_code      (code)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int done_seen = 0;

  logic [8:0] exp_q [$];   // {tlast, tdata}

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       prev_stall   = 1'b0;
  logic [7:0] prev_data    = 8'h00;
  logic       prev_last    = 1'b0;
  logic       prev_last_hs = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(m_tvalid), 1);
        chk("stall_data", int'(m_tdata), int'(prev_data));
        chk("stall_last", int'(m_tlast), int'(prev_last));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", int'(m_tdata), -1);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("beat_data", int'(m_tdata), int'(e[7:0]));
          chk("beat_last", int'(m_tlast), int'(e[8]));
        end
      end
      if (m_tvalid) chk("rx_ready_in_drain", int'(s_tready), 0);
      if (prev_last_hs) chk("done_after_last", int'(done), 1);
      else if (done) chk("spurious_done", int'(done), 0);
      if (err) begin
        err_seen++;
        chk("busy_low_on_err", int'(busy), 0);
      end
      if (done) done_seen++;
      prev_stall   = m_tvalid & ~m_tready;
      prev_data    = m_tdata;
      prev_last    = m_tlast;
      prev_last_hs = m_tvalid & m_tready & m_tlast;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic send(input logic [7:0] b);
    int waited = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    while (!s_tready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!s_tready) chk("send_timeout", waited, 0);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("queue_drained", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_at64(input logic [63:0] s, input int i);
    return s[63-8*i -: 8];
  endfunction

  function automatic logic [7:0] byte_at32(input logic [31:0] s, input int i);
    return s[31-8*i -: 8];
  endfunction

  typedef struct {
    logic [63:0] in_s;     // input bytes, first byte in the top octet
    int          n_in;
    logic [31:0] exp_s;    // expected payload beats, first in the top octet
    int          n_exp;
    int          n_err;
    logic [1:0]  code;     // err_code expected after the vector
  } vec_t;

  vec_t vecs [8];

  initial begin
    int e0, d0;
    logic [7:0] sum;

    vecs[0] = '{64'hA503112233690000, 6, 32'h11223300, 3, 0, 2'd0}; // good frame
    vecs[1] = '{64'hA502102000000000, 5, 32'h00000000, 0, 1, 2'd2}; // bad checksum
    vecs[2] = '{64'hA5017E7F00000000, 4, 32'h7E000000, 1, 0, 2'd2}; // LEN=1
    vecs[3] = '{64'h00FF5AA5017E7F00, 7, 32'h7E000000, 1, 0, 2'd2}; // hunt
    vecs[4] = '{64'hA500000000000000, 2, 32'h00000000, 0, 1, 2'd1}; // LEN=0
    vecs[5] = '{64'hA541000000000000, 2, 32'h00000000, 0, 1, 2'd1}; // LEN=65
    vecs[6] = '{64'hA501000100000000, 4, 32'h00000000, 1, 0, 2'd1}; // payload 00
    vecs[7] = '{64'hA502A5A54C000000, 5, 32'hA5A50000, 2, 0, 2'd1}; // HDR in payload

    rst = 1'b1; s_tdata = 8'h00; s_tvalid = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_s_tready", int'(s_tready), 1);
    chk("rst_m_tvalid", int'(m_tvalid), 0);
    chk("rst_m_tlast", int'(m_tlast), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_code", int'(code), 0);

    // ---------------- table-driven frames ----------------
    for (int v = 0; v < 8; v++) begin
      e0 = err_seen;
      d0 = done_seen;
      for (int j = 0; j < vecs[v].n_exp; j++)
        exp_q.push_back({(j == vecs[v].n_exp - 1), byte_at32(vecs[v].exp_s, j)});
      for (int j = 0; j < vecs[v].n_in; j++) begin
        send(byte_at64(vecs[v].in_s, j));
        if (j == 3 && v == 0) chk("busy_mid_frame", int'(busy), 1);
      end
      if (vecs[v].n_exp > 0) chk("first_beat_latency", int'(m_tvalid), 1);
      wait_drain();
      chk("err_pulses", err_seen - e0, vecs[v].n_err);
      chk("done_pulses", done_seen - d0, (vecs[v].n_exp > 0) ? 1 : 0);
      chk("err_code", int'(code), int'(vecs[v].code));
      chk("busy_idle", int'(busy), 0);
    end

    // ---------------- backpressure: tready 1,0,1,0 ----------------
    d0 = done_seen;
    for (int j = 1; j <= 4; j++) exp_q.push_back({(j == 4), 8'(j)});
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h0E);
    chk("bp_first_valid", int'(m_tvalid), 1);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      m_tready = (k % 2 == 0);
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    wait_drain();
    chk("bp_done_pulses", done_seen - d0, 1);

    // ---------------- LEN == MAX_LEN ----------------
    d0 = done_seen;
    sum = 8'(MAX_LEN);
    send(8'hA5);
    send(8'(MAX_LEN));
    for (int j = 0; j < MAX_LEN; j++) begin
      logic [7:0] b;
      b = 8'(j * 7 + 3);
      sum = sum + b;
      exp_q.push_back({(j == MAX_LEN - 1), b});
      send(b);
    end
    send(sum);
    wait_drain();
    chk("maxlen_done", done_seen - d0, 1);

    // ---------------- reset mid-frame ----------------
    e0 = err_seen;
    send(8'hA5); send(8'h03); send(8'h11);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_code", int'(code), 0);
    exp_q.push_back({1'b1, 8'h7E});
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    wait_drain();
    chk("midrst_no_err", err_seen - e0, 0);

    // ---------------- stalled frame ----------------
    e0 = err_seen;
    send(8'hA5); send(8'h02); send(8'h10);
`ifdef UART_UNPACK_TIMEOUT_EN
    begin
      int k;
      for (k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (err) break;
      end
      // Pulse is registered by the edge closing the 16th idle cycle.
      chk("tmo_cycle", k, TMO + 1);
      chk("tmo_code", int'(code), 3);
      chk("tmo_busy", int'(busy), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("tmo_err_pulses", err_seen - e0, 1);
    end
`else
    repeat (100) @(posedge clk);
    #1;
    chk("stall_busy", int'(busy), 1);
    chk("stall_no_err", err_seen - e0, 0);
    exp_q.push_back({1'b0, 8'h10});
    exp_q.push_back({1'b1, 8'h20});
    send(8'h20); send(8'h32);
    wait_drain();
    chk("stall_resume_busy", int'(busy), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_axis_unpacker.md
Name: uart_axis_unpacker

Overview:
- Receive-side counterpart of the UART upload packer.
- Takes the raw byte stream from the UART RX (AXI-Stream, 8-bit) and hunts for command frames of the form HDR, LEN, payload[LEN], CHK.
- Buffers the payload and releases it on an AXI-Stream master, with tlast on the last byte, only after the checksum passes.
- Bad frames are dropped and reported with an error pulse plus an error code.

Parameters:
- HDR_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 64, maximum payload bytes per frame; legal range 1..255.
- TIMEOUT_CYCLES, 1024, consecutive idle cycles mid-frame before abort; used only with the optional feature.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- s_axis_tdata  input  8  received UART byte
- s_axis_tvalid  input  1  byte valid
- s_axis_tready  output  1  byte accepted
- m_axis_tdata  output  8  payload byte
- m_axis_tvalid  output  1  payload valid
- m_axis_tready  input  1  downstream ready
- m_axis_tlast  output  1  last payload byte of frame
- frame_busy  output  1  high from the accepted HDR until frame completion or abort
- frame_done  output  1  1-cycle pulse after the tlast handshake
- frame_err  output  1  1-cycle pulse on frame abort
- err_code  output  2  code of the last error; 1=bad LEN, 2=checksum, 3=timeout

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=HUNT.
  - s_axis_tready=1.
  - m_axis_tvalid=0, m_axis_tlast=0.
  - frame_busy=0, frame_done=0, frame_err=0, err_code=0.
  - Pointers and checksum = 0.
- Reset mid-frame or mid-drain aborts with no pulse. The buffer contents become don't-care.
- A byte is accepted when s_axis_tvalid & s_axis_tready.
- s_axis_tready=1 in states HUNT, LEN, DATA and CHK. It is 0 in DRAIN, so no RX overlap with output.
- HUNT:
  - An accepted byte equal to HDR_BYTE moves to LEN and sets frame_busy.
  - Any other byte is discarded silently.
- LEN:
  - Accepted byte of 0, or greater than MAX_LEN: frame_err pulse, err_code<=1, go to HUNT.
  - Otherwise latch len, set sum<=byte, wr_ptr<=0, go to DATA.
- DATA:
  - Each accepted byte is written to buf[wr_ptr], then sum<=sum+byte (mod 256) and wr_ptr++.
  - When the byte at wr_ptr==len-1 is accepted, go to CHK.
  - HDR_BYTE inside the payload is plain data; there is no resync.
- CHK:
  - Accepted byte == sum: go to DRAIN with rd_ptr<=0.
  - Otherwise: frame_err pulse, err_code<=2, go to HUNT.
- DRAIN:
  - m_axis_tvalid=1 starting the cycle after the CHK byte is accepted.
  - m_axis_tdata=buf[rd_ptr]. m_axis_tlast = (rd_ptr==len-1).
  - On each handshake, rd_ptr++.
  - tdata and tlast stay stable while tvalid & !tready.
  - On the tlast handshake: tvalid<=0, frame_busy<=0, frame_done=1 for the following cycle, go to HUNT.
  - The first new byte can be accepted in that same following cycle.
- Error handling:
  - frame_err and frame_busy deassertion happen in the same cycle.
  - err_code holds its value until the next error or reset.
- Widths:
  - len, wr_ptr and rd_ptr are clog2(MAX_LEN+1) bits.
  - sum is 8 bits and wraps.
  - The buffer is MAX_LEN x 8.
- Throughput:
  - 1 byte/cycle in.
  - 1 byte/cycle out when m_axis_tready is high.
- Latency: first payload byte is valid 1 cycle after the CHK byte is accepted.
- Boundaries:
  - LEN==MAX_LEN fills the buffer exactly and is legal.
  - LEN==1 produces a single beat with tlast=1.

Optional Feature:
- Macro: UART_UNPACK_TIMEOUT_EN.
- With the macro:
  - An idle counter runs in LEN, DATA and CHK.
  - It clears on each accepted byte and on entry to those states.
  - It increments each cycle with no accepted byte.
  - When it reaches TIMEOUT_CYCLES: frame_err pulse, err_code<=3, go to HUNT.
  - The counter is inactive in HUNT and DRAIN.
- Without the macro: no counter logic, TIMEOUT_CYCLES is ignored, and a stalled frame waits indefinitely.

Decomposition:
- Package uart_frame_pkg holds:
  - HDR_BYTE default.
  - err_code constants ERR_NONE, ERR_LEN, ERR_CHK, ERR_TMO.
  - State encoding HUNT, LEN, DATA, CHK, DRAIN.
- One sub-module, uart_frame_buf:
  - Register-array buffer, MAX_LEN deep.
  - Synchronous write port, asynchronous read by rd_ptr.
- Checksum, pointers and FSM stay in the top module.

Test Plan:
- Good frame, tready=1. Input A5 03 11 22 33 69 → m_axis carries 11, 22, 33 with tlast on 33. frame_done pulses 1 cycle after that handshake. No frame_err.
- Bad checksum. Input A5 02 10 20 00 → no m_axis beats, frame_err 1 cycle, err_code=2. A following A5 01 7E 7F yields a single beat 7E with tlast.
- Hunt. Input 00 FF 5A A5 01 7E 7F → only 7E is output; leading bytes are dropped with no error.
- Bad length. Input A5 00, then A5 41 with MAX_LEN=64 → two frame_err pulses, err_code=1 each time. Then A5 01 00 01 yields a beat 00.
- Backpressure.
  - Stimulus: A5 04 01 02 03 04 0E with m_axis_tready toggling 1,0,1,0.
  - Response: beats 01..04 in order, tdata stable during stalls, s_axis_tready=0 throughout DRAIN.
- Timeout, macro defined, TIMEOUT_CYCLES=16. Input A5 02 10, then no tvalid → frame_err on the 16th idle cycle, err_code=3, frame_busy=0. Without the macro the FSM is still in DATA after 100 cycles.
